// File: rtl/debug_mem_dumper.sv
// Debug memory dumper: halts the pipeline and streams data memory MSB-first to UART TX.
// Optional trailing XOR checksum byte when DEBUG_DUMP_CHECKSUM_EN is defined.
module debug_mem_dumper #(
   parameter int MEM_BYTES = 256,
   parameter int ADDR_W    = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   output logic              o_halt,
   output logic [ADDR_W-1:0] o_r_addr,
   input  logic [31:0]       i_r_data,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_busy,
   output logic              o_done
);

`ifdef DEBUG_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LOAD, SEND, FINISH, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, SEND, FINISH} state_t;
`endif

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

   state_t            state, state_d;
   logic              halt_d, valid_d, busy_d, done_d;
   logic [ADDR_W-1:0] addr_d;
   logic [7:0]        data_d;
   // The top byte goes straight to o_tx_data, so only the remaining three are kept.
   logic [23:0]       rest, rest_d;
   logic [1:0]        cnt, cnt_d;
   logic              xfer, last_word;
`ifdef DEBUG_DUMP_CHECKSUM_EN
   logic [7:0]        csum, csum_d;
`endif

   assign xfer      = o_tx_valid & i_tx_ready;
   assign last_word = (o_r_addr == LAST_ADDR);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         o_halt     <= 1'b0;
         o_r_addr   <= '0;
         o_tx_data  <= '0;
         o_tx_valid <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         rest       <= '0;
         cnt        <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         state      <= state_d;
         o_halt     <= halt_d;
         o_r_addr   <= addr_d;
         o_tx_data  <= data_d;
         o_tx_valid <= valid_d;
         o_busy     <= busy_d;
         o_done     <= done_d;
         rest       <= rest_d;
         cnt        <= cnt_d;
`ifdef DEBUG_DUMP_CHECKSUM_EN
         csum       <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:   if (i_start) state_d = LOAD;
         LOAD:   state_d = SEND;
         SEND: begin
            if (xfer && cnt == 2'd3) begin
               if (last_word)
`ifdef DEBUG_DUMP_CHECKSUM_EN
                  state_d = CHK;
`else
                  state_d = FINISH;
`endif
               else
                  state_d = LOAD;
            end
         end
`ifdef DEBUG_DUMP_CHECKSUM_EN
         CHK:    if (xfer) state_d = FINISH;
`endif
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      halt_d  = o_halt;
      addr_d  = o_r_addr;
      data_d  = o_tx_data;
      valid_d = o_tx_valid;
      done_d  = 1'b0;
      busy_d  = (state_d != IDLE);
      rest_d  = rest;
      cnt_d   = cnt;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum_d  = csum;
`endif
      case (state)
         IDLE: begin
            if (i_start) begin
               halt_d = 1'b1;
               addr_d = '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
               csum_d = '0;
`endif
            end
         end
         LOAD: begin
            rest_d  = i_r_data[23:0];
            cnt_d   = '0;
            data_d  = i_r_data[31:24];
            valid_d = 1'b1;
         end
         SEND: begin
            if (xfer) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
               csum_d = csum ^ o_tx_data;
`endif
               if (cnt != 2'd3) begin
                  data_d = rest[23:16];
                  rest_d = {rest[15:0], 8'h00};
                  cnt_d  = cnt + 2'd1;
               end else begin
                  valid_d = 1'b0;
                  if (last_word) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                     data_d  = csum ^ o_tx_data;
                     valid_d = 1'b1;
`endif
                  end else begin
                     addr_d = o_r_addr + ADDR_W'(4);
                  end
               end
            end
         end
`ifdef DEBUG_DUMP_CHECKSUM_EN
         CHK:    if (xfer) valid_d = 1'b0;
`endif
         FINISH: begin
            done_d = 1'b1;
            halt_d = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Randomized self-checking bench for debug_mem_dumper against a byte-stream model.
module tb_debug_mem_dumper;
   localparam int MB = 256;
   localparam int NW = MB / 4;
`ifdef DEBUG_DUMP_CHECKSUM_EN
   localparam int NB = MB + 1;
`else
   localparam int NB = MB;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic        i_tx_ready = 1'b0;
   logic        o_halt, o_tx_valid, o_busy, o_done;
   logic [31:0] o_r_addr;
   logic [31:0] i_r_data;
   logic [7:0]  o_tx_data;

   logic [31:0] mem [0:NW-1];
   logic [7:0]  exp_b [0:NB-1];
   logic [7:0]  got [0:NB-1];

   int   checks = 0;
   int   failures = 0;
   int   nbytes = 0;
   int   done_cnt = 0;
   int   rdy_mode = 0;
   bit   mon_en = 1'b0;
   logic pv = 1'b0;
   logic pr = 1'b0;
   logic [7:0] pd = 8'h00;

   always #5 i_clk = ~i_clk;

   assign i_r_data = mem[o_r_addr[7:2]];

   debug_mem_dumper #(.MEM_BYTES(MB), .ADDR_W(32)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
      .o_halt(o_halt), .o_r_addr(o_r_addr), .i_r_data(i_r_data),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
      .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_done(o_done)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected stream: each word MSB first, then optionally the XOR of all bytes.
   task automatic build_exp();
      logic [7:0]  x;
      logic [31:0] v;
      x = 8'h00;
      for (int w = 0; w < NW; w++)
         for (int b = 0; b < 4; b++) begin
            v = mem[w] >> (8 * (3 - b));
            exp_b[4*w+b] = v[7:0];
            x ^= v[7:0];
         end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      exp_b[MB] = x;
`endif
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_halt"}, o_halt, 1);
      chk({tag, "_halt"}, o_halt, 0);
      checks--;
      checks--;
      checks++;
   endtask

   always @(negedge i_clk) begin
      if (mon_en) begin
         chk("busy_eq_halt", o_busy, o_halt);
         if (pv && !pr) begin
            chk("hold_valid", o_tx_valid, 1);
            chk("hold_data", o_tx_data, pd);
         end
         if (o_tx_valid) chk("halt_while_valid", o_halt, 1);
         if (o_tx_valid && i_tx_ready) begin
            if (nbytes < NB) begin
               chk("byte", o_tx_data, exp_b[nbytes]);
               if (nbytes < MB) chk("addr", o_r_addr, (nbytes / 4) * 4);
               got[nbytes] = o_tx_data;
            end else begin
               chk("extra_byte", nbytes, NB - 1);
            end
            nbytes++;
         end
         if (o_done) begin
            done_cnt++;
            chk("bytes_at_done", nbytes, NB);
         end
         pv = o_tx_valid;
         pr = i_tx_ready;
         pd = o_tx_data;
      end
   end

   initial forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
         0: i_tx_ready = 1'b1;
         1: i_tx_ready = ($urandom_range(0, 99) < 30);
         default: i_tx_ready = 1'b0;
      endcase
   end

   task automatic begin_run(input int rmode);
      build_exp();
      nbytes = 0;
      done_cnt = 0;
      pv = 1'b0;
      rdy_mode = rmode;
      mon_en = 1'b1;
   endtask

   task automatic run_dump(input int rmode, input int restart_at,
                           input int exp_cycles);
      int n;
      begin_run(rmode);
      @(posedge i_clk);
      #1;
      i_start = 1'b1;
      n = 0;
      while (n < 20000) begin
         @(posedge i_clk);
         #1;
         n++;
         i_start = (n == restart_at);
         if (o_done) break;
      end
      i_start = 1'b0;
      chk("done_seen", o_done, 1);
      if (exp_cycles > 0) chk("done_latency", n, exp_cycles);
      repeat (3) @(posedge i_clk);
      #1;
      chk("done_count", done_cnt, 1);
      chk("byte_count", nbytes, NB);
      chk("halt_after", o_halt, 0);
      chk("busy_after", o_busy, 0);
      mon_en = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_halt"}, o_halt, 0);
      chk({tag, "_valid"}, o_tx_valid, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_addr"}, o_r_addr, 0);
      chk({tag, "_data"}, o_tx_data, 0);
   endtask

   initial begin
      int n;
      int seen;
      for (int k = 0; k < NW; k++) mem[k] = 32'hA0B0C0D0 + k;
      repeat (3) @(posedge i_clk);
      #1;
      chk_reset_state("rst_held");
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;
      chk_reset_state("rst_rel");

      run_dump(0, 0, 2 + 5 * NW + NB - MB);
      chk("got0", got[0], 8'hA0);
      chk("got3", got[3], 8'hD0);
      chk("got7", got[7], 8'hD1);
      chk("got255", got[255], 8'h0F);

      for (int k = 0; k < NW; k++) mem[k] = $urandom;
      run_dump(1, 40, 0);
      for (int k = 0; k < NW; k++) mem[k] = $urandom;
      run_dump(1, 700, 0);

      i_reset = 1'b1;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      chk_reset_state("rst_idle");

      for (int k = 0; k < NW; k++) mem[k] = $urandom;
      begin_run(0);
      @(posedge i_clk);
      #1;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      n = 0;
      while (nbytes < 22 && n < 1000) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      rdy_mode = 2;
      i_tx_ready = 1'b0;
      mon_en = 1'b0;
      chk("pre_rst_valid", o_tx_valid, 1);
      chk("pre_rst_data", o_tx_data, exp_b[22]);
      chk("pre_rst_addr", o_r_addr, 20);
      i_reset = 1'b1;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      chk_reset_state("rst_mid");
      seen = 0;
      repeat (20) begin
         @(posedge i_clk);
         #1;
         if (o_done || o_halt || o_tx_valid) seen++;
      end
      chk("quiet_after_rst", seen, 0);

      for (int k = 0; k < NW; k++) mem[k] = 32'h01020304;
      run_dump(1, 0, 0);
      chk("const_b0", got[0], 8'h01);
      chk("const_b255", got[255], 8'h04);
`ifdef DEBUG_DUMP_CHECKSUM_EN
      chk("csum_byte", got[MB], 8'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
